// File: rtl/nms_pkg.sv
// -----------------------------------------------------------------------------
// nms_pkg
// Shared constants for the NMS CSR bank: byte addresses of the fixed
// registers, the base of the threshold arrays, and bit positions inside
// the CTRL and STATUS words.
// -----------------------------------------------------------------------------
package nms_pkg;

    // Fixed register byte addresses (word aligned)
    localparam int ADDR_CTRL     = 32'h0000_0000;
    localparam int ADDR_NUM_PRED = 32'h0000_0004;
    localparam int ADDR_STATUS   = 32'h0000_0008;
    localparam int ADDR_NUM_BOX  = 32'h0000_000C;
    // IOU_THRESH[c] at base+4c, S_THRESH[c] at base+4*NUM_CLS+4c
    localparam int ADDR_THR_BASE = 32'h0000_0010;

    // CTRL bits
    localparam int CTRL_START_BIT  = 32'd0;
    localparam int CTRL_IRQ_EN_BIT = 32'd1;

    // STATUS bits
    localparam int STAT_BUSY_BIT = 32'd0;
    localparam int STAT_DONE_BIT = 32'd1;
    localparam int STAT_ERR_BIT  = 32'd2;

endpackage

// File: rtl/nms_csr_bank.sv
// -----------------------------------------------------------------------------
// nms_csr_bank
// Host-visible control/status registers for the NMS core.
//   Host bus : reg_wren/reg_rden/reg_addr/reg_wdata in, reg_rdata/reg_rvalid out
//              (read data registered, one cycle after reg_rden).
//   Core side: core_done/core_num_box in; start pulse, busy, num_pred and the
//              packed per-class iou_thresh/s_thresh arrays out.
//   irq      : level output, IRQ_EN & (DONE | ERR).
// Configuration (NUM_PRED, thresholds) and START are locked while busy; a
// locked write is dropped and flags ERR. Everything is synchronous to clk,
// gen_rst is a synchronous active-high reset.
// -----------------------------------------------------------------------------
module nms_csr_bank
    import nms_pkg::*;
#(
    parameter int REG_DATA_WIDTH   = 32,
    parameter int REG_ADDR_WIDTH   = 8,
    parameter int BBOX_IND_WIDTH   = 14,
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int IOU_THRESH_WIDTH = 16,
    parameter int NUM_CLS          = 4
)(
    input  logic                                  clk,
    input  logic                                  gen_rst,
    input  logic                                  reg_wren,
    input  logic                                  reg_rden,
    input  logic [REG_ADDR_WIDTH-1:0]             reg_addr,
    input  logic [REG_DATA_WIDTH-1:0]             reg_wdata,
    output logic [REG_DATA_WIDTH-1:0]             reg_rdata,
    output logic                                  reg_rvalid,
    input  logic                                  core_done,
    input  logic [MEM_ADDR_WIDTH-1:0]             core_num_box,
    output logic                                  start,
    output logic                                  busy,
    output logic [BBOX_IND_WIDTH-1:0]             num_pred,
    output logic [NUM_CLS*IOU_THRESH_WIDTH-1:0]   iou_thresh,
    output logic [NUM_CLS*IOU_THRESH_WIDTH-1:0]   s_thresh,
    output logic                                  irq
);

    localparam int AW = REG_ADDR_WIDTH;
    localparam int TW = IOU_THRESH_WIDTH;

    // Address decode
    logic [AW-1:0] w_addr_al;
    logic [AW-1:0] w_thr_idx;
    logic          w_hit_ctrl, w_hit_npred, w_hit_stat, w_hit_nbox, w_hit_thr;

    assign w_addr_al   = {reg_addr[AW-1:2], 2'b00};
    // Index 0..NUM_CLS-1 selects IOU_THRESH, NUM_CLS..2*NUM_CLS-1 selects S_THRESH
    assign w_thr_idx   = (w_addr_al - AW'(ADDR_THR_BASE)) >> 2'd2;
    assign w_hit_ctrl  = (w_addr_al == AW'(ADDR_CTRL));
    assign w_hit_npred = (w_addr_al == AW'(ADDR_NUM_PRED));
    assign w_hit_stat  = (w_addr_al == AW'(ADDR_STATUS));
    assign w_hit_nbox  = (w_addr_al == AW'(ADDR_NUM_BOX));
    assign w_hit_thr   = (w_addr_al >= AW'(ADDR_THR_BASE)) &&
                         (w_thr_idx < AW'(2 * NUM_CLS));

    // Low address bits are ignored; wdata is only partly used per register
    logic w_unused_bits;
    assign w_unused_bits = ^{reg_addr[1:0], reg_wdata};

    // State registers
    logic                      r_busy, r_done, r_err, r_irq_en, r_irq, r_start;
    logic [BBOX_IND_WIDTH-1:0] r_num_pred;
    logic [MEM_ADDR_WIDTH-1:0] r_num_box;
    logic [REG_DATA_WIDTH-1:0] r_rdata;
    logic                      r_rvalid;
    logic [TW-1:0]             w_iou_arr [NUM_CLS];
    logic [TW-1:0]             w_s_arr   [NUM_CLS];

    // Events; an access is judged against the registered busy, so a START or
    // config write in the same cycle as core_done still counts as "while busy"
    logic w_start_req, w_start_ok, w_start_err;
    logic w_cfg_wr, w_cfg_ok, w_cfg_err, w_done_evt;

    assign w_start_req = reg_wren && w_hit_ctrl && reg_wdata[CTRL_START_BIT];
    assign w_start_ok  = w_start_req && !r_busy;
    assign w_start_err = w_start_req && r_busy;
    assign w_cfg_wr    = reg_wren && (w_hit_npred || w_hit_thr);
    assign w_cfg_ok    = w_cfg_wr && !r_busy;
    assign w_cfg_err   = w_cfg_wr && r_busy;
    assign w_done_evt  = core_done && r_busy;

    logic w_busy_nxt, w_done_nxt, w_err_nxt, w_irq_en_nxt, w_irq_nxt;

    // Next-state for control/status flags; hardware sets take priority over W1C
    always_comb begin
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        w_irq_en_nxt = r_irq_en;

        if (w_start_ok) begin
            w_busy_nxt = 1'b1;
        end else if (w_done_evt) begin
            w_busy_nxt = 1'b0;
        end else begin
            w_busy_nxt = r_busy;
        end

        if (w_done_evt) begin
            w_done_nxt = 1'b1;
        end else if (w_start_ok) begin
            w_done_nxt = 1'b0;
        end else if (reg_wren && w_hit_stat && reg_wdata[STAT_DONE_BIT]) begin
            w_done_nxt = 1'b0;
        end else begin
            w_done_nxt = r_done;
        end

        if (w_start_err || w_cfg_err) begin
            w_err_nxt = 1'b1;
        end else if (reg_wren && w_hit_stat && reg_wdata[STAT_ERR_BIT]) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end

        if (reg_wren && w_hit_ctrl) begin
            w_irq_en_nxt = reg_wdata[CTRL_IRQ_EN_BIT];
        end else begin
            w_irq_en_nxt = r_irq_en;
        end

        // irq is registered from next-state so it lines up with the flags
        w_irq_nxt = w_irq_en_nxt && (w_done_nxt || w_err_nxt);
    end

    // Read mux over the current (pre-write) register contents
    logic [REG_DATA_WIDTH-1:0] w_rd_mux;
    logic [TW-1:0]             w_thr_rd;

    always_comb begin
        w_thr_rd = '0;
        for (int c = 0; c < NUM_CLS; c++) begin
            w_thr_rd = w_thr_rd
                     | ((w_thr_idx == AW'(c))           ? w_iou_arr[c] : {TW{1'b0}})
                     | ((w_thr_idx == AW'(NUM_CLS + c)) ? w_s_arr[c]   : {TW{1'b0}});
        end

        w_rd_mux = '0;
        if (w_hit_ctrl) begin
            w_rd_mux[CTRL_IRQ_EN_BIT] = r_irq_en;
        end else if (w_hit_npred) begin
            w_rd_mux[BBOX_IND_WIDTH-1:0] = r_num_pred;
        end else if (w_hit_stat) begin
            w_rd_mux[STAT_BUSY_BIT] = r_busy;
            w_rd_mux[STAT_DONE_BIT] = r_done;
            w_rd_mux[STAT_ERR_BIT]  = r_err;
        end else if (w_hit_nbox) begin
            w_rd_mux[MEM_ADDR_WIDTH-1:0] = r_num_box;
        end else if (w_hit_thr) begin
            w_rd_mux[TW-1:0] = w_thr_rd;
        end else begin
            w_rd_mux = '0;
        end
    end

    // Control, status, count and read-response registers
    always_ff @(posedge clk) begin
        if (gen_rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
            r_start    <= 1'b0;
            r_num_pred <= '0;
            r_num_box  <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= w_irq_nxt;
            r_start  <= w_start_ok;
            r_rvalid <= reg_rden;
            if (w_cfg_ok && w_hit_npred) begin
                r_num_pred <= reg_wdata[BBOX_IND_WIDTH-1:0];
            end
            if (w_done_evt) begin
                r_num_box <= core_num_box;
            end
            if (reg_rden) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // Per-class threshold registers
    for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
        logic [TW-1:0] r_iou_thr;
        logic [TW-1:0] r_s_thr;

        // Class c IoU and score threshold, writable only while idle
        always_ff @(posedge clk) begin
            if (gen_rst) begin
                r_iou_thr <= '0;
                r_s_thr   <= '0;
            end else begin
                if (w_cfg_ok && w_hit_thr && (w_thr_idx == AW'(c))) begin
                    r_iou_thr <= reg_wdata[TW-1:0];
                end
                if (w_cfg_ok && w_hit_thr && (w_thr_idx == AW'(NUM_CLS + c))) begin
                    r_s_thr <= reg_wdata[TW-1:0];
                end
            end
        end

        assign w_iou_arr[c]             = r_iou_thr;
        assign w_s_arr[c]               = r_s_thr;
        assign iou_thresh[c*TW +: TW]   = r_iou_thr;
        assign s_thresh[c*TW +: TW]     = r_s_thr;
    end

    assign reg_rdata  = r_rdata;
    assign reg_rvalid = r_rvalid;
    assign start      = r_start;
    assign busy       = r_busy;
    assign num_pred   = r_num_pred;
    assign irq        = r_irq;

endmodule

// File: tb/tb_nms_csr_bank.sv
// -----------------------------------------------------------------------------
// tb_nms_csr_bank
// Directed vector table for the documented scenarios, hand sequences for the
// same-cycle corner cases and reset mid-run, then a randomized phase checked
// against a register-map level reference model.
// -----------------------------------------------------------------------------
module tb_nms_csr_bank;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = 14;
    localparam int MW = 10;
    localparam int TW = 16;
    localparam int NC = 4;

    logic                 clk = 1'b0;
    logic                 gen_rst;
    logic                 reg_wren, reg_rden;
    logic [AW-1:0]        reg_addr;
    logic [DW-1:0]        reg_wdata;
    logic [DW-1:0]        reg_rdata;
    logic                 reg_rvalid;
    logic                 core_done;
    logic [MW-1:0]        core_num_box;
    logic                 start, busy, irq;
    logic [BW-1:0]        num_pred;
    logic [NC*TW-1:0]     iou_thresh, s_thresh;

    always #5 clk = ~clk;

    nms_csr_bank #(
        .REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .BBOX_IND_WIDTH(BW),
        .MEM_ADDR_WIDTH(MW), .IOU_THRESH_WIDTH(TW), .NUM_CLS(NC)
    ) dut (
        .clk(clk), .gen_rst(gen_rst), .reg_wren(reg_wren), .reg_rden(reg_rden),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_rvalid(reg_rvalid), .core_done(core_done), .core_num_box(core_num_box),
        .start(start), .busy(busy), .num_pred(num_pred), .iou_thresh(iou_thresh),
        .s_thresh(s_thresh), .irq(irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [7:0] a,
                         input logic [31:0] d, input logic cd, input logic [9:0] nb);
        reg_wren     = wr;
        reg_rden     = rd;
        reg_addr     = a;
        reg_wdata    = d;
        core_done    = cd;
        core_num_box = nb;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        drive(1'b0, 1'b1, a, 32'd0, 1'b0, 10'd0);
        step();
        chk({name, ".rvalid"}, 64'(reg_rvalid), 64'd1);
        chk({name, ".rdata"}, 64'(reg_rdata), 64'(exp));
        drive(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 10'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        cd;
        logic [9:0]  nb;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_start;
        logic        e_busy;
        logic        e_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d,
                       input logic cd, input logic [9:0] nb, input logic ev, input logic [31:0] er,
                       input logic es, input logic eb, input logic ei);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.cd = cd; v.nb = nb;
        v.e_rvalid = ev; v.e_rdata = er; v.e_start = es; v.e_busy = eb; v.e_irq = ei;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [BW-1:0] m_np;
    logic [MW-1:0] m_nb;
    logic [TW-1:0] m_iou [NC];
    logic [TW-1:0] m_s   [NC];
    bit            m_busy, m_done, m_err, m_ien, m_start, m_rvalid;
    logic [31:0]   m_rdata;

    task automatic m_reset();
        m_np = '0; m_nb = '0;
        for (int c = 0; c < NC; c++) begin
            m_iou[c] = '0;
            m_s[c]   = '0;
        end
        m_busy = 0; m_done = 0; m_err = 0; m_ien = 0; m_start = 0; m_rvalid = 0;
        m_rdata = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] r;
        int w;
        r = '0;
        w = int'(a) / 4;
        if (w == 0) r[1] = m_ien;
        else if (w == 1) r = 32'(m_np);
        else if (w == 2) begin r[0] = m_busy; r[1] = m_done; r[2] = m_err; end
        else if (w == 3) r = 32'(m_nb);
        else if (w >= 4 && w < 4 + NC) r = 32'(m_iou[w - 4]);
        else if (w >= 4 + NC && w < 4 + 2 * NC) r = 32'(m_s[w - 4 - NC]);
        return r;
    endfunction

    task automatic m_apply(input logic wr, input logic rd, input logic [7:0] a,
                           input logic [31:0] d, input logic cd, input logic [9:0] nb);
        logic [31:0] pre;
        bit busy0;
        int w;
        pre     = m_read(a);
        busy0   = m_busy;
        m_start = 0;
        w       = int'(a) / 4;
        if (wr) begin
            if (w == 0) begin
                m_ien = d[1];
                if (d[0]) begin
                    if (busy0) m_err = 1;
                    else begin m_start = 1; m_busy = 1; m_done = 0; end
                end
            end else if (w == 1) begin
                if (busy0) m_err = 1; else m_np = d[BW-1:0];
            end else if (w == 2) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end else if (w >= 4 && w < 4 + 2 * NC) begin
                if (busy0) m_err = 1;
                else if (w < 4 + NC) m_iou[w - 4] = d[TW-1:0];
                else m_s[w - 4 - NC] = d[TW-1:0];
            end
        end
        // hardware completion is applied after host clears, so it wins
        if (cd && busy0) begin
            m_busy = 0; m_done = 1; m_nb = nb;
        end
        m_rvalid = rd;
        if (rd) m_rdata = pre;
    endtask

    function automatic logic [NC*TW-1:0] m_pack(input bit sel_s);
        logic [NC*TW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*TW +: TW] = sel_s ? m_s[c] : m_iou[c];
        return r;
    endfunction

    initial begin
        drive(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 10'd0);
        gen_rst = 1'b1;
        repeat (3) step();
        chk("rst.start", 64'(start), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.irq", 64'(irq), 64'd0);
        chk("rst.rvalid", 64'(reg_rvalid), 64'd0);
        gen_rst = 1'b0;

        //  wr rd addr   wdata       cd nb     rv rdata        st bs irq
        add(0, 1, 8'h00, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(0, 1, 8'h04, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(0, 1, 8'h08, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(0, 1, 8'h0C, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(0, 1, 8'h10, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(0, 1, 8'h2C, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(1, 0, 8'h04, 32'd100,    0, 10'd0,  0, 32'h0,      0, 0, 0);
        add(1, 0, 8'h10, 32'h4000,   0, 10'd0,  0, 32'h0,      0, 0, 0);
        add(0, 1, 8'h04, 32'h0,      0, 10'd0,  1, 32'd100,    0, 0, 0);
        add(0, 1, 8'h10, 32'h0,      0, 10'd0,  1, 32'h4000,   0, 0, 0);
        add(1, 0, 8'h00, 32'h1,      0, 10'd0,  0, 32'h4000,   1, 1, 0);
        add(0, 0, 8'h00, 32'h0,      0, 10'd0,  0, 32'h4000,   0, 1, 0);
        add(1, 0, 8'h00, 32'h1,      0, 10'd0,  0, 32'h4000,   0, 1, 0);
        add(1, 0, 8'h14, 32'h1234,   0, 10'd0,  0, 32'h4000,   0, 1, 0);
        add(0, 1, 8'h08, 32'h0,      0, 10'd0,  1, 32'h5,      0, 1, 0);
        add(0, 1, 8'h14, 32'h0,      0, 10'd0,  1, 32'h0,      0, 1, 0);
        add(0, 0, 8'h00, 32'h0,      1, 10'd37, 0, 32'h0,      0, 0, 0);
        add(1, 0, 8'h08, 32'h4,      0, 10'd0,  0, 32'h0,      0, 0, 0);
        add(0, 1, 8'h08, 32'h0,      0, 10'd0,  1, 32'h2,      0, 0, 0);
        add(0, 1, 8'h0C, 32'h0,      0, 10'd0,  1, 32'd37,     0, 0, 0);
        add(1, 0, 8'h00, 32'h2,      0, 10'd0,  0, 32'd37,     0, 0, 1);
        add(0, 1, 8'h00, 32'h0,      0, 10'd0,  1, 32'h2,      0, 0, 1);
        add(1, 0, 8'h08, 32'h2,      0, 10'd0,  0, 32'h2,      0, 0, 0);
        add(0, 1, 8'h08, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(1, 0, 8'h2C, 32'hBEEF,   0, 10'd0,  0, 32'h0,      0, 0, 0);
        add(0, 1, 8'h2C, 32'h0,      0, 10'd0,  1, 32'hBEEF,   0, 0, 0);
        add(0, 1, 8'h2E, 32'h0,      0, 10'd0,  1, 32'hBEEF,   0, 0, 0);
        add(0, 1, 8'h30, 32'h0,      0, 10'd0,  1, 32'h0,      0, 0, 0);
        add(1, 1, 8'h04, 32'd55,     0, 10'd0,  1, 32'd100,    0, 0, 0);
        add(0, 1, 8'h04, 32'h0,      0, 10'd0,  1, 32'd55,     0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].cd, vecs[i].nb);
            step();
            chk($sformatf("vec%0d.rvalid", i), 64'(reg_rvalid), 64'(vecs[i].e_rvalid));
            chk($sformatf("vec%0d.rdata", i),  64'(reg_rdata),  64'(vecs[i].e_rdata));
            chk($sformatf("vec%0d.start", i),  64'(start),      64'(vecs[i].e_start));
            chk($sformatf("vec%0d.busy", i),   64'(busy),       64'(vecs[i].e_busy));
            chk($sformatf("vec%0d.irq", i),    64'(irq),        64'(vecs[i].e_irq));
        end
        drive(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 10'd0);
        chk("out.num_pred", 64'(num_pred), 64'd55);
        chk("out.iou0", 64'(iou_thresh[15:0]), 64'h4000);
        chk("out.s3", 64'(s_thresh[63:48]), 64'hBEEF);

        // W1C of DONE in the same cycle as core_done: the set wins
        drive(1'b1, 1'b0, 8'h00, 32'h3, 1'b0, 10'd0);
        step();
        chk("seqA.start", 64'(start), 64'd1);
        chk("seqA.busy", 64'(busy), 64'd1);
        drive(1'b1, 1'b0, 8'h08, 32'h2, 1'b1, 10'd5);
        step();
        chk("seqA.busy_after", 64'(busy), 64'd0);
        chk("seqA.irq", 64'(irq), 64'd1);
        rd_chk(8'h08, 32'h2, "seqA.status");

        // START in the same cycle as core_done: judged busy, errors, no pulse
        drive(1'b1, 1'b0, 8'h00, 32'h3, 1'b0, 10'd0);
        step();
        chk("seqB.busy", 64'(busy), 64'd1);
        drive(1'b1, 1'b0, 8'h00, 32'h3, 1'b1, 10'd9);
        step();
        chk("seqB.start", 64'(start), 64'd0);
        chk("seqB.busy_after", 64'(busy), 64'd0);
        drive(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 10'd0);
        step();
        chk("seqB.start_next", 64'(start), 64'd0);
        rd_chk(8'h08, 32'h6, "seqB.status");
        rd_chk(8'h0C, 32'd9, "seqB.num_box");

        // Reset while busy
        drive(1'b1, 1'b0, 8'h08, 32'h6, 1'b0, 10'd0);
        step();
        drive(1'b1, 1'b0, 8'h00, 32'h1, 1'b0, 10'd0);
        step();
        chk("seqC.busy", 64'(busy), 64'd1);
        drive(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 10'd0);
        gen_rst = 1'b1;
        step();
        step();
        gen_rst = 1'b0;
        chk("seqC.busy_rst", 64'(busy), 64'd0);
        chk("seqC.irq_rst", 64'(irq), 64'd0);
        chk("seqC.iou_rst", 64'(iou_thresh), 64'd0);
        chk("seqC.s_rst", 64'(s_thresh), 64'd0);
        chk("seqC.np_rst", 64'(num_pred), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("seqC.nostart%0d", k), 64'(start), 64'd0);
        end
        rd_chk(8'h00, 32'h0, "seqC.ctrl");

        // Randomized phase against the reference model
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            int op, w;
            logic wr, rd, cd;
            logic [7:0] a;
            logic [31:0] d;
            logic [9:0] nb;
            op = int'($urandom_range(0, 9));
            wr = (op <= 3) || (op == 7);
            rd = (op >= 4 && op <= 7);
            w  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 4 + 2 * NC));
            a  = 8'(w * 4 + int'($urandom_range(0, 3)));
            d  = $urandom;
            cd = ($urandom_range(0, 5) == 0);
            nb = 10'($urandom);
            drive(wr, rd, a, d, cd, nb);
            if ($urandom_range(0, 199) == 0) begin
                gen_rst = 1'b1;
                m_reset();
            end else begin
                gen_rst = 1'b0;
                m_apply(wr, rd, a, d, cd, nb);
            end
            step();
            gen_rst = 1'b0;
            chk($sformatf("rnd%0d.start", n),  64'(start),      64'(m_start));
            chk($sformatf("rnd%0d.busy", n),   64'(busy),       64'(m_busy));
            chk($sformatf("rnd%0d.irq", n),    64'(irq),        64'(m_ien && (m_done || m_err)));
            chk($sformatf("rnd%0d.rvalid", n), 64'(reg_rvalid), 64'(m_rvalid));
            chk($sformatf("rnd%0d.rdata", n),  64'(reg_rdata),  64'(m_rdata));
            chk($sformatf("rnd%0d.np", n),     64'(num_pred),   64'(m_np));
            chk($sformatf("rnd%0d.iou", n),    64'(iou_thresh), 64'(m_pack(1'b0)));
            chk($sformatf("rnd%0d.s", n),      64'(s_thresh),   64'(m_pack(1'b1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
